// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared SC types and helpers: FSM state encoding, window length, saturation
package sc_pkg;

   typedef enum logic [1:0] {
      SC_IDLE  = 2'd0,
      SC_COUNT = 2'd1,
      SC_DONE  = 2'd2
   } sc_state_e;

   function automatic int sc_window_len(input int data_width);
      return 1 << data_width;
   endfunction

   // Clamp a signed value into [lo, hi]; reused by every SC block that packs counts into codes
   function automatic int sc_saturate(input int value, input int lo, input int hi);
      if (value < lo) return lo;
      if (value > hi) return hi;
      return value;
   endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// rtl/sc_ones_counter.sv - per-lane ones counter with saturated output code (SC_BIPOLAR_EN selects bipolar)
module sc_ones_counter
   import sc_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic                  inc,
   output logic [DATA_WIDTH-1:0] value
);

   localparam int N = sc_window_len(DATA_WIDTH);

   // One extra bit so a full window of ones (N) is representable before saturation
   logic [DATA_WIDTH:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (en) begin
         if (clr) begin
            count <= '0;
         end else if (inc) begin
            count <= count + 1'b1;
         end
      end
   end

`ifdef SC_BIPOLAR_EN
   assign value = DATA_WIDTH'(sc_saturate(int'(count) - N / 2, -(N / 2), N / 2 - 1));
`else
   assign value = DATA_WIDTH'(sc_saturate(int'(count), 0, N - 1));
`endif

endmodule

// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - stochastic-to-binary window decoder top (SC_BIPOLAR_EN selects bipolar codes)
module sc_stream_decoder
   import sc_pkg::*;
#(
   parameter int DATA_WIDTH = 4,
   parameter int NUM_INPUTS = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic                             start,
   input  logic                             sc_valid,
   input  logic [NUM_INPUTS-1:0]            sc_data_in,
   output logic                             busy,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_out,
   output logic                             done
);

   localparam logic [1:0] IDLE  = SC_IDLE;
   localparam logic [1:0] COUNT = SC_COUNT;
   localparam logic [1:0] DONE  = SC_DONE;

   localparam logic [DATA_WIDTH:0] LAST_BIT = (DATA_WIDTH + 1)'(sc_window_len(DATA_WIDTH) - 1);

   logic [1:0]                       state;
   logic [DATA_WIDTH:0]              bit_cnt;
   logic [NUM_INPUTS*DATA_WIDTH-1:0] lane_value;
   logic                             start_ok;
   logic                             accept;

   assign start_ok = start && ((state == IDLE) || (state == DONE));
   assign accept   = (state == COUNT) && sc_valid;
   assign busy     = (state == COUNT);

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
      sc_ones_counter #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .clr   (start_ok),
         .inc   (accept && sc_data_in[i]),
         .value (lane_value[i*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   // Results are captured in DONE, so done rises one cycle after the last valid bit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         bin_data_out <= '0;
         done         <= 1'b0;
      end else if (!en) begin
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bit_cnt <= '0;
                  state   <= COUNT;
               end
            end
            COUNT: begin
               if (sc_valid) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == LAST_BIT) state <= DONE;
               end
            end
            DONE: begin
               bin_data_out <= lane_value;
               done         <= 1'b1;
               if (start) begin
                  bit_cnt <= '0;
                  state   <= COUNT;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
Stochastic-to-binary converter. It is the receiving end of the bitstreams that the SC serial datapath (the sc_serial_mul generators) emits.
- Counts the ones in NUM_INPUTS parallel unipolar bitstreams over a fixed window of 2^DATA_WIDTH valid bits.
- Returns the packed binary magnitudes with a one-cycle done pulse.
- Sits between the SC datapath output and the core-level bin_data_out / op_finished.

Parameters:
DATA_WIDTH, 4, binary precision per lane; window length N = 2^DATA_WIDTH bits
NUM_INPUTS, 2, number of parallel bitstream lanes

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous reset, active-low
en  input  1  global enable; when low, state and counters hold
start  input  1  begin a new decode window (sampled in IDLE or DONE only)
sc_valid  input  1  sc_data_in carries a valid bit this cycle
sc_data_in  input  NUM_INPUTS  one stochastic bit per lane
busy  output  1  high while in COUNT
bin_data_out  output  NUM_INPUTS*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
done  output  1  one-cycle pulse when bin_data_out updates

Behaviour:
- Interface decision: one clock (clk); reset rst is asynchronous and active-low. While rst=0: state=IDLE, all counters 0, bin_data_out=0, done=0, busy=0.
- All updates are gated by en. With en=0, nothing changes and done is forced 0 on the next edge.
- FSM states: IDLE, COUNT, DONE.
  - IDLE: start=1 clears lane counters and bit counter, then goes to COUNT.
  - COUNT: each cycle with sc_valid=1, bit counter +1 and lane counter i +1 if sc_data_in[i]=1. sc_valid=0 stalls (no count, no timeout). start is ignored. When the valid bit that makes the bit counter reach N is accepted, go to DONE.
  - DONE (one cycle): bin_data_out is registered from the lane counters and done=1. A new start in this cycle goes directly to COUNT (back-to-back windows, no idle gap); otherwise go to IDLE.
- Counters: lane and bit counters are DATA_WIDTH+1 bits wide. The ones count ranges 0..N.
- Unipolar output = count saturated to 2^DATA_WIDTH-1, so an all-ones stream gives max code.
- Latency: done asserts 1 cycle after the Nth valid bit is accepted. With no stalls, the first result comes N+1 cycles after start.
- bin_data_out holds its value until the next DONE. It is never cleared by start.
- Reset mid-window: everything returns to reset values immediately, and the partial count is discarded.
- Simultaneous start and sc_valid in IDLE: the start cycle's sc_data_in is not counted. Counting begins the cycle after.

Optional Feature:
Macro SC_BIPOLAR_EN.
- Defined: each lane output is bipolar two's complement, count - 2^(DATA_WIDTH-1), saturated to the range [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: unipolar saturated magnitude as above.
- Timing and handshake are identical in both modes.

Decomposition:
- Package sc_pkg holds:
  - state enum typedef (IDLE/COUNT/DONE)
  - function sc_window_len(DATA_WIDTH)
  - saturation helper function shared with other SC blocks
- Sub-module sc_ones_counter: one per lane, generated NUM_INPUTS times. Holds the counter, clear, increment-enable and saturated output. The FSM and bit counter stay in the top.

Test Plan:
- DATA_WIDTH=4, start, 16 valid bits: lane0=all ones, lane1=all zeros -> done after 17 cycles; lane0=15 (saturated), lane1=0; bin_data_out=8'h0F.
- lane0 pattern with 5 ones, lane1 with 11 ones in 16 bits, sc_valid deasserted for 3 cycles mid-window -> done at cycle 20; bin_data_out=8'hB5.
- Back-to-back: start held high in DONE -> second window starts with no gap; second done 17 cycles after first.
- rst pulled low at valid bit 8 -> outputs 0 immediately; a fresh start gives a correct full-window count with no residue.
- en low for 4 cycles during COUNT -> done delayed by exactly 4 cycles; result unchanged.
- SC_BIPOLAR_EN: lane counts 16, 8, 0 -> 4'h7, 4'h0, 4'h8 (-8).
